// File: rtl/systolic_operand_loader_pkg.sv
// Shared constants, state encoding and operand bit-offset helpers for the
// systolic array operand loader.
package systolic_operand_loader_pkg;

  localparam int IN_DIM         = 4;
  localparam int F_DIM          = 3;
  localparam int DW             = 8;
  localparam int FRAME_LEN      = IN_DIM * IN_DIM + F_DIM * F_DIM;
  localparam int RUN_CYCLES_DEF = 20;

  localparam int I_BITS = DW * IN_DIM * IN_DIM;
  localparam int F_BITS = DW * F_DIM * F_DIM;
  localparam int IDX_W  = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Bit offset of element (r, c) inside a flattened dim x dim matrix.
  function automatic int elem_off(input int r, input int c, input int dim);
    return DW * (dim * r + c);
  endfunction

  // Byte position of element (r, c) within the serial frame.
  function automatic int frame_pos(input int r, input int c, input int dim, input int base);
    return base + dim * r + c;
  endfunction

endpackage

// File: rtl/systolic_operand_loader_if.sv
// Byte stream carrying one operand frame into the loader.
interface systolic_operand_loader_if
  import systolic_operand_loader_pkg::*;
  ();

  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/systolic_operand_loader_run_counter.sv
// Wrapping terminal-count counter with synchronous clear and enable; used for
// both the frame byte index and the array run timer.
module loader_run_counter #(
  parameter int WIDTH = 5,
  parameter int TC    = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == WIDTH'(TC)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/systolic_operand_loader.sv
// Collects one serial operand frame, presents it to the systolic array,
// times the array run and holds done until the consumer acknowledges.
module systolic_operand_loader
  import systolic_operand_loader_pkg::*;
#(
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst,
  systolic_operand_loader_if.slave  s,
  output logic [I_BITS-1:0]         i_mat,
  output logic [F_BITS-1:0]         f_mat,
  output logic                      array_rst,
  output logic                      busy,
  output logic                      done,
  input  logic                      done_ack,
  output logic                      err
);

  localparam int RUN_W = $clog2(RUN_CYCLES + 1);

  loader_state_e     state_q;
  logic              s_ready_q;
  logic              array_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [I_BITS-1:0] i_mat_q;
  logic [F_BITS-1:0] f_mat_q;

  logic              xfer_s;
  logic [IDX_W-1:0]  idx_s;
  logic              idx_tc_s;
  logic [RUN_W-1:0]  run_cnt_s;
  logic              run_tc_s;

  assign xfer_s = s.s_valid & s_ready_q;

  // A frame-ending byte (good or short) restarts the index; a long frame wraps.
  loader_run_counter #(
    .WIDTH (IDX_W),
    .TC    (FRAME_LEN - 1)
  ) u_idx_cnt (
    .clk_i (clk_in),
    .rst_i (rst),
    .clr_i (xfer_s & s.s_last),
    .en_i  (xfer_s),
    .cnt_o (idx_s)
  );

  loader_run_counter #(
    .WIDTH (RUN_W),
    .TC    (RUN_CYCLES - 1)
  ) u_run_cnt (
    .clk_i (clk_in),
    .rst_i (rst),
    .clr_i (state_q != RUN),
    .en_i  (state_q == RUN),
    .cnt_o (run_cnt_s)
  );

  assign idx_tc_s = (idx_s == IDX_W'(FRAME_LEN - 1));
  assign run_tc_s = (run_cnt_s == RUN_W'(RUN_CYCLES - 1));

  // Control FSM; every output is registered alongside the state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= LOAD;
      s_ready_q   <= 1'b1;
      array_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer_s) begin
            if (s.s_last && idx_tc_s) begin
              state_q     <= RUN;
              err_q       <= 1'b0;
              s_ready_q   <= 1'b0;
              array_rst_q <= 1'b0;
              busy_q      <= 1'b1;
            end else if (s.s_last || idx_tc_s) begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (run_tc_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (done_ack) begin
            state_q     <= LOAD;
            done_q      <= 1'b0;
            s_ready_q   <= 1'b1;
            array_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= LOAD;
          s_ready_q   <= 1'b1;
          array_rst_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
        end
      endcase
    end
  end

  // Operand storage; writes only happen on transfers, so RUN/DONE freeze it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      i_mat_q <= '0;
      f_mat_q <= '0;
    end else if (xfer_s) begin
      for (int r = 0; r < IN_DIM; r++) begin
        for (int c = 0; c < IN_DIM; c++) begin
          if (idx_s == IDX_W'(frame_pos(r, c, IN_DIM, 0))) begin
            i_mat_q[elem_off(r, c, IN_DIM) +: DW] <= s.s_data;
          end
        end
      end
      for (int r = 0; r < F_DIM; r++) begin
        for (int c = 0; c < F_DIM; c++) begin
          if (idx_s == IDX_W'(frame_pos(r, c, F_DIM, IN_DIM * IN_DIM))) begin
            f_mat_q[elem_off(r, c, F_DIM) +: DW] <= s.s_data;
          end
        end
      end
    end
  end

  assign s.s_ready = s_ready_q;
  assign i_mat     = i_mat_q;
  assign f_mat     = f_mat_q;
  assign array_rst = array_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Randomized bench for systolic_operand_loader, checked every cycle against a
// frame-level behavioural model.
module tb_systolic_operand_loader;
  import systolic_operand_loader_pkg::*;

  localparam int NI = IN_DIM * IN_DIM;
  localparam int NF = F_DIM * F_DIM;

  logic              clk_in = 1'b0;
  logic              rst = 1'b1;
  logic              done_ack = 1'b0;
  logic [I_BITS-1:0] i_mat;
  logic [F_BITS-1:0] f_mat;
  logic              array_rst, busy, done, err;

  systolic_operand_loader_if sif ();

  systolic_operand_loader dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .s         (sif),
    .i_mat     (i_mat),
    .f_mat     (f_mat),
    .array_rst (array_rst),
    .busy      (busy),
    .done      (done),
    .done_ack  (done_ack),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  typedef enum {M_LOAD, M_RUN, M_DONE} mphase_e;
  mphase_e      m_ph;
  int           m_pos, m_run;
  bit           m_err;
  byte unsigned m_i [NI];
  byte unsigned m_f [NF];

  int cyc = 0;
  int t_last, busy_rise, done_rise, rel_cycles;
  bit prev_busy, prev_done;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph  = M_LOAD;
    m_pos = 0;
    m_run = 0;
    m_err = 1'b0;
    foreach (m_i[k]) m_i[k] = 8'd0;
    foreach (m_f[k]) m_f[k] = 8'd0;
  endfunction

  // Applies the inputs present just before an edge to the model.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      case (m_ph)
        M_LOAD: if (sif.s_valid) begin
          if (m_pos < NI) m_i[m_pos] = sif.s_data;
          else            m_f[m_pos - NI] = sif.s_data;
          if (sif.s_last) begin
            if (m_pos == FRAME_LEN - 1) begin
              m_ph   = M_RUN;
              m_run  = 0;
              m_err  = 1'b0;
              t_last = cyc;
            end else begin
              m_err = 1'b1;
            end
            m_pos = 0;
          end else if (m_pos == FRAME_LEN - 1) begin
            m_err = 1'b1;
            m_pos = 0;
          end else begin
            m_pos++;
          end
        end
        M_RUN: begin
          m_run++;
          if (m_run == RUN_CYCLES_DEF) m_ph = M_DONE;
        end
        M_DONE: if (done_ack) m_ph = M_LOAD;
        default: model_reset();
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [I_BITS-1:0] ei;
    logic [F_BITS-1:0] ef;
    for (int k = 0; k < NI; k++) ei[DW*k +: DW] = m_i[k];
    for (int k = 0; k < NF; k++) ef[DW*k +: DW] = m_f[k];
    check_val("i_mat",     i_mat,       ei);
    check_val("f_mat",     f_mat,       ef);
    check_val("s_ready",   sif.s_ready, m_ph == M_LOAD);
    check_val("array_rst", array_rst,   m_ph == M_LOAD);
    check_val("busy",      busy,        m_ph == M_RUN);
    check_val("done",      done,        m_ph == M_DONE);
    check_val("err",       err,         m_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    cyc++;
    check_outputs();
    if (busy === 1'b1 && !prev_busy) busy_rise = cyc;
    if (done === 1'b1 && !prev_done) done_rise = cyc;
    if (array_rst === 1'b0 && done === 1'b0) rel_cycles++;
    prev_busy = (busy === 1'b1);
    prev_done = (done === 1'b1);
  endtask

  task automatic clear_trk();
    busy_rise  = -1;
    done_rise  = -1;
    rel_cycles = 0;
  endtask

  // kind: 0 = 1..n, 1 = 0xFF, 2 = random. gap: 0 none, 1 alternate, 2 random.
  task automatic send_frame(input int n, input int last_at, input int kind, input int gap);
    for (int i = 0; i < n; i++) begin
      sif.s_data  = (kind == 0) ? 8'(i + 1) : (kind == 1) ? 8'hFF : 8'($urandom);
      sif.s_valid = 1'b1;
      sif.s_last  = (i + 1 == last_at);
      step();
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = 8'($urandom);
        step();
      end
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check_val({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic ack_done(input string tag);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    check_val({tag, "_ack_done"},  done,        1'b0);
    check_val({tag, "_ack_ready"}, sif.s_ready, 1'b1);
  endtask

  initial begin
    sif.s_data  = 8'd0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    prev_busy   = 1'b0;
    prev_done   = 1'b0;
    t_last      = 0;
    model_reset();
    clear_trk();

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_val("rst_array_rst", array_rst, 1'b1);
    check_val("rst_i_mat", i_mat, 128'd0);
    step();

    // Sequential frame with latency measurements.
    clear_trk();
    send_frame(FRAME_LEN, FRAME_LEN, 0, 0);
    wait_done("t1");
    check_val("t1_busy_lat", 128'(busy_rise - t_last), 128'd1);
    check_val("t1_done_lat", 128'(done_rise - t_last), 128'(1 + RUN_CYCLES_DEF));
    check_val("t1_rel_cycles", 128'(rel_cycles), 128'(RUN_CYCLES_DEF));
    check_val("t1_i00", i_mat[7:0], 8'd1);
    check_val("t1_f22", f_mat[F_BITS-1 -: 8], 8'd25);
    ack_done("t1");

    // All-0xFF frame with a bubble after every byte.
    clear_trk();
    send_frame(FRAME_LEN, FRAME_LEN, 1, 1);
    wait_done("t2");
    check_val("t2_done_lat", 128'(done_rise - t_last), 128'(1 + RUN_CYCLES_DEF));
    ack_done("t2");

    // Short frame, then a good one.
    send_frame(10, 10, 2, 0);
    for (int i = 0; i < 30; i++) step();
    check_val("t3_err_short", err, 1'b1);
    send_frame(FRAME_LEN, FRAME_LEN, 2, 2);
    wait_done("t3");
    check_val("t3_err_clear", err, 1'b0);
    ack_done("t3");

    // Long frame, then a good one.
    send_frame(FRAME_LEN, 0, 2, 0);
    check_val("t4_err_long", err, 1'b1);
    check_val("t4_no_run", busy, 1'b0);
    for (int i = 0; i < 5; i++) step();
    send_frame(FRAME_LEN, FRAME_LEN, 2, 2);
    wait_done("t4");
    ack_done("t4");

    // Long done hold with stream noise, then ack while a byte is offered.
    send_frame(FRAME_LEN, FRAME_LEN, 2, 0);
    wait_done("t5");
    for (int i = 0; i < 50; i++) begin
      sif.s_valid = 1'($urandom_range(0, 1));
      sif.s_data  = 8'($urandom);
      step();
    end
    check_val("t5_hold_done", done, 1'b1);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hAA;
    done_ack    = 1'b1;
    step();
    done_ack    = 1'b0;
    sif.s_valid = 1'b0;
    check_val("t5_ack_array_rst", array_rst, 1'b1);
    check_val("t5_ack_done", done, 1'b0);
    step();

    // Reset in the fifth RUN cycle.
    send_frame(FRAME_LEN, FRAME_LEN, 2, 0);
    for (int i = 0; i < 4; i++) step();
    check_val("t6_in_run", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_run_rst_busy", busy, 1'b0);
    check_val("t6_run_rst_i_mat", i_mat, 128'd0);

    // Reset on byte 12 of a frame.
    send_frame(11, 0, 2, 0);
    sif.s_data  = 8'($urandom);
    sif.s_valid = 1'b1;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    sif.s_valid = 1'b0;
    check_val("t6_frame_rst_i_mat", i_mat, 128'd0);
    check_val("t6_frame_rst_array_rst", array_rst, 1'b1);
    send_frame(FRAME_LEN, FRAME_LEN, 2, 2);
    wait_done("t6");
    ack_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
